// File: rtl/matmul_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// matmul_ctrl_pkg
// Shared definitions for the matrix-multiply job sequencer:
//   - ctrl_state_t : controller state encoding (IDLE, RUN, DONE)
//   - DIM_W        : width of the N/K/M dimension fields
//   - max_dim()    : largest square dimension the array supports
//   - dim_valid()  : dimension legality check (1..max inclusive)
// ---------------------------------------------------------------------------
package matmul_ctrl_pkg;

  localparam int DIM_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ctrl_state_t;

  // One result element has to hold a full operand product sum, so the
  // array edge length is the ratio of result width to operand width.
  function automatic int max_dim(input int bus_width, input int data_width);
    return bus_width / data_width;
  endfunction

  function automatic logic dim_valid(input logic [DIM_W-1:0] dim, input int max_d);
    return (dim != '0) && (int'(dim) <= max_d);
  endfunction

endpackage

// File: rtl/matmul_acc_unit.sv
// ---------------------------------------------------------------------------
// matmul_acc_unit
// Combinational result-update datapath for every matrix element at once.
// Ports:
//   acc_mode   : 0 = replace C with array result, 1 = C + array result
//   c_old      : currently held result matrix (flattened)
//   c_new      : result matrix delivered by the array
//   flags_old  : currently held sticky overflow flags
//   flags_new  : overflow flags delivered by the array
//   c_next     : matrix to store on capture
//   flags_next : flags to store on capture
// ---------------------------------------------------------------------------
module matmul_acc_unit
  import matmul_ctrl_pkg::*;
#(
  parameter int BUS_WIDTH = 16,
  parameter int ELEMS     = 4
) (
  input  logic                       acc_mode,
  input  logic [ELEMS*BUS_WIDTH-1:0] c_old,
  input  logic [ELEMS*BUS_WIDTH-1:0] c_new,
  input  logic [ELEMS-1:0]           flags_old,
  input  logic [ELEMS-1:0]           flags_new,
  output logic [ELEMS*BUS_WIDTH-1:0] c_next,
  output logic [ELEMS-1:0]           flags_next
);

  for (genvar e = 0; e < ELEMS; e++) begin : g_elem
    logic [BUS_WIDTH-1:0] old_e;
    logic [BUS_WIDTH-1:0] new_e;
    logic [BUS_WIDTH-1:0] sum_e;
    logic                 ovf_e;

    assign old_e = c_old[e*BUS_WIDTH +: BUS_WIDTH];
    assign new_e = c_new[e*BUS_WIDTH +: BUS_WIDTH];
    assign sum_e = old_e + new_e;

    // Signed overflow: both addends share a sign but the wrapped sum does not.
    assign ovf_e = (old_e[BUS_WIDTH-1] == new_e[BUS_WIDTH-1]) &&
                   (sum_e[BUS_WIDTH-1] != old_e[BUS_WIDTH-1]);

    assign c_next[e*BUS_WIDTH +: BUS_WIDTH] = acc_mode ? sum_e : new_e;
    assign flags_next[e] = acc_mode ? (flags_old[e] | flags_new[e] | ovf_e)
                                    : flags_new[e];
  end

endmodule

// File: rtl/matmul_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// matmul_ctrl_fsm
// Job sequencer in front of the systolic matrix-multiply array.
// Ports:
//   clk_i, rst_i                 : clock, synchronous active-high reset
//   cmd_valid_i / cmd_ready_o    : job handshake
//   n/k/m_dim_i, acc_mode_i      : job dimensions and accumulate select
//   a_matrix_i, b_matrix_i       : flattened row-major operands
//   res_valid_o / res_ready_i    : result handshake
//   c_matrix_o, flags_o, err_o   : held result, sticky overflow, abort status
//   busy_o                       : controller not idle
//   mm_start_o                   : start level to the array
//   mm_*_dim_o, mm_*_matrix_o    : job parameters latched at accept
//   mm_c_matrix_i, mm_flags_i    : array result and overflow flags
//   mm_finish_i                  : array done
// ---------------------------------------------------------------------------
module matmul_ctrl_fsm
  import matmul_ctrl_pkg::*;
#(
  parameter  int DATA_WIDTH     = 8,
  parameter  int BUS_WIDTH      = 16,
  parameter  int TIMEOUT_CYCLES = 64,
  localparam int MAX_DIM        = max_dim(BUS_WIDTH, DATA_WIDTH),
  localparam int ELEMS          = MAX_DIM * MAX_DIM,
  localparam int OP_W           = ELEMS * DATA_WIDTH,
  localparam int RES_W          = ELEMS * BUS_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [DIM_W-1:0] n_dim_i,
  input  logic [DIM_W-1:0] k_dim_i,
  input  logic [DIM_W-1:0] m_dim_i,
  input  logic             acc_mode_i,
  input  logic [OP_W-1:0]  a_matrix_i,
  input  logic [OP_W-1:0]  b_matrix_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [RES_W-1:0] c_matrix_o,
  output logic [ELEMS-1:0] flags_o,
  output logic             err_o,
  output logic             busy_o,
  output logic             mm_start_o,
  output logic [DIM_W-1:0] mm_n_dim_o,
  output logic [DIM_W-1:0] mm_k_dim_o,
  output logic [DIM_W-1:0] mm_m_dim_o,
  output logic [OP_W-1:0]  mm_a_matrix_o,
  output logic [OP_W-1:0]  mm_b_matrix_o,
  input  logic [RES_W-1:0] mm_c_matrix_i,
  input  logic [ELEMS-1:0] mm_flags_i,
  input  logic             mm_finish_i
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  ctrl_state_t      state;
  logic [CNT_W-1:0] run_cnt;
  logic             acc_mode_q;
  logic [RES_W-1:0] c_next;
  logic [ELEMS-1:0] flags_next;
  logic             dims_ok;

  assign dims_ok = dim_valid(n_dim_i, MAX_DIM) &&
                   dim_valid(k_dim_i, MAX_DIM) &&
                   dim_valid(m_dim_i, MAX_DIM);

  matmul_acc_unit #(
    .BUS_WIDTH (BUS_WIDTH),
    .ELEMS     (ELEMS)
  ) u_acc (
    .acc_mode   (acc_mode_q),
    .c_old      (c_matrix_o),
    .c_new      (mm_c_matrix_i),
    .flags_old  (flags_o),
    .flags_new  (mm_flags_i),
    .c_next     (c_next),
    .flags_next (flags_next)
  );

  // Single sequencing process; every output is a register so the array and
  // the bus front end both see glitch-free levels. A bad-dimension job skips
  // RUN entirely, so the array never sees a start level for it. Finish is
  // tested before timeout, so a finish on the last allowed cycle still counts.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= IDLE;
      run_cnt       <= '0;
      acc_mode_q    <= 1'b0;
      cmd_ready_o   <= 1'b1;
      res_valid_o   <= 1'b0;
      err_o         <= 1'b0;
      busy_o        <= 1'b0;
      mm_start_o    <= 1'b0;
      c_matrix_o    <= '0;
      flags_o       <= '0;
      mm_n_dim_o    <= '0;
      mm_k_dim_o    <= '0;
      mm_m_dim_o    <= '0;
      mm_a_matrix_o <= '0;
      mm_b_matrix_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid_i) begin
            mm_n_dim_o    <= n_dim_i;
            mm_k_dim_o    <= k_dim_i;
            mm_m_dim_o    <= m_dim_i;
            mm_a_matrix_o <= a_matrix_i;
            mm_b_matrix_o <= b_matrix_i;
            acc_mode_q    <= acc_mode_i;
            run_cnt       <= '0;
            cmd_ready_o   <= 1'b0;
            busy_o        <= 1'b1;
            if (dims_ok) begin
              state      <= RUN;
              err_o      <= 1'b0;
              mm_start_o <= 1'b1;
            end else begin
              state       <= DONE;
              err_o       <= 1'b1;
              res_valid_o <= 1'b1;
            end
          end
        end
        RUN: begin
          if (mm_finish_i) begin
            c_matrix_o  <= c_next;
            flags_o     <= flags_next;
            state       <= DONE;
            mm_start_o  <= 1'b0;
            res_valid_o <= 1'b1;
          end else if (run_cnt == CNT_LAST) begin
            err_o       <= 1'b1;
            state       <= DONE;
            mm_start_o  <= 1'b0;
            res_valid_o <= 1'b1;
          end else begin
            run_cnt <= run_cnt + 1'b1;
          end
        end
        DONE: begin
          if (res_ready_i) begin
            state       <= IDLE;
            res_valid_o <= 1'b0;
            cmd_ready_o <= 1'b1;
            busy_o      <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          res_valid_o <= 1'b0;
          cmd_ready_o <= 1'b1;
          busy_o      <= 1'b0;
          mm_start_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/matmul_ctrl_fsm.md
# matmul_ctrl_fsm

Job sequencer for the systolic matrix-multiply array. Accepts one multiply job per valid/ready handshake, validates dimensions, drives the array's start level until it reports finish, and captures or accumulates the result matrix and overflow flags. Returns the result through a valid/ready handshake with error status. Sits between the register/bus front end and the array instance.

## Interface
- DATA_WIDTH, 8, operand element width
- BUS_WIDTH, 16, result element width; MAX_DIM = BUS_WIDTH/DATA_WIDTH (localparam)
- TIMEOUT_CYCLES, 64, maximum RUN cycles before abort
- clk_i  in  1  single clock, rising edge
- rst_i  in  1  reset, synchronous, active-high
- cmd_valid_i  in  1  job offered
- cmd_ready_o  out  1  controller can accept job
- n_dim_i, k_dim_i, m_dim_i  in  3 each  A is NxK, B is KxM
- acc_mode_i  in  1  0: C=A*B, 1: C=C+A*B
- a_matrix_i, b_matrix_i  in  MAX_DIM*MAX_DIM*DATA_WIDTH each  flattened operands, row-major
- res_valid_o  out  1  result/status valid
- res_ready_i  in  1  consumer takes result
- c_matrix_o  out  MAX_DIM*MAX_DIM*BUS_WIDTH  held result matrix
- flags_o  out  MAX_DIM*MAX_DIM  per-element overflow, sticky across accumulation
- err_o  out  1  job aborted (bad dims or timeout)
- busy_o  out  1  state != IDLE
- mm_start_o  out  1  start level to array
- mm_n_dim_o, mm_k_dim_o, mm_m_dim_o  out  3 each  latched dims
- mm_a_matrix_o, mm_b_matrix_o  out  operand width  latched operands
- mm_c_matrix_i  in  MAX_DIM*MAX_DIM*BUS_WIDTH  array result
- mm_flags_i  in  MAX_DIM*MAX_DIM  array overflow flags
- mm_finish_i  in  1  array done (registered in array)

## Operation
- States: IDLE, RUN, DONE.
- IDLE: cmd_ready_o=1, mm_start_o=0. On cmd_valid_i&&cmd_ready_o latch dims, operands, acc_mode; clear err_o. Dims valid iff each in 1..MAX_DIM: go RUN. Else err_o=1, go DONE; no start pulse issued, C/flags unchanged.
- RUN: mm_start_o=1; run counter increments each cycle from 0. On mm_finish_i=1: capture result, go DONE. If counter reaches TIMEOUT_CYCLES-1 without finish: err_o=1, C/flags unchanged, go DONE.
- Capture: acc_mode=0 → C=mm_c, flags=mm_flags. acc_mode=1 → per element C=C+mm_c, wrap modulo 2^BUS_WIDTH, signed; flags |= mm_flags | signed-add overflow of that element.
- DONE: res_valid_o=1, mm_start_o=0. On res_ready_i go IDLE.
- Outputs c_matrix_o/flags_o hold between jobs; changed only at capture or reset.
- mm_* operand/dim outputs stable from accept until next accept.

## Timing
- Reset: state IDLE, cmd_ready_o=1, res_valid_o=0, err_o=0, busy_o=0, mm_start_o=0, c_matrix_o=0, flags_o=0, latched dims/operands 0.
- Accept edge → mm_start_o high the next cycle.
- mm_finish_i sampled high in RUN → capture on that edge; res_valid_o high next cycle; mm_start_o low in the same cycle.
- With the array (finish after N+K+M-1 start cycles), res_valid_o rises N+K+M+1 cycles after the accept edge.
- mm_start_o low for ≥2 cycles between jobs (DONE + IDLE) so the array counter clears.
- res_ready_i already high on entry to DONE: res_valid_o high exactly one cycle.
- cmd_valid_i outside IDLE ignored; no command buffering.
- mm_finish_i outside RUN ignored.
- Finish and timeout in the same cycle: finish wins, err_o=0.
- Reset mid-RUN: mm_start_o low the next cycle, all outputs at reset values.

## Structure
- Package matmul_ctrl_pkg: state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2), MAX_DIM helper, dim-valid function.
- Sub-module matmul_acc_unit: combinational per-element add/select plus overflow flag generation, instantiated once over the full flattened matrix.

## Test plan
- 2x2x2, A={1,2,3,4}, B={5,6,7,8}, acc_mode=0 with array → C={19,22,43,50}, flags=0, err_o=0, res_valid_o 7 cycles after accept.
- Same job repeated with acc_mode=1 → C={38,44,86,100}; third job with acc_mode=0 → C back to {19,22,43,50}.
- n_dim=0 (and separately k_dim=3) → err_o=1, res_valid_o next cycle, mm_start_o never high, C unchanged.
- Stub array never finishing → err_o=1 after 64 RUN cycles, mm_start_o drops, C/flags unchanged.
- Accumulate C element 32767 + 1 → element 0x8000, its flag=1; res_ready_i low 5 cycles → result held, cmd_ready_o=0, and cmd_valid_i in that window is ignored.
- rst_i asserted in RUN cycle 3 → next cycle all outputs at reset values; a new job then completes normally.
